// File: rtl/uop_pkg.sv
// Shared uop types and queue sizing for the decode-to-backend path.
package uop_pkg;

   localparam int INSTR_Q_WIDTH = 4;
   localparam int UQ_DEPTH      = 16;

   typedef logic [$clog2(UQ_DEPTH)-1:0] uq_ptr_t;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
   } instr_queue_t;

   typedef struct packed {
      logic [31:0] pc;
      logic [6:0]  opcode;
      logic [4:0]  rd;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic [31:0] imm;
   } uop_t;

endpackage

// File: rtl/uop_queue_if.sv
// Decode-side enqueue and backend-side dispatch bundle of the uop queue.
interface uop_queue_if
   import uop_pkg::*;
#(
   parameter int WIDTH = INSTR_Q_WIDTH,
   parameter int DEPTH = UQ_DEPTH
);

   logic                      flush_in;
   logic [WIDTH-1:0]          enq_valid_in;
   uop_t [WIDTH-1:0]          enq_uop_in;
   logic                      enq_ready_out;
   logic [WIDTH-1:0]          deq_valid_out;
   uop_t [WIDTH-1:0]          deq_uop_out;
   logic                      deq_ready_in;
   logic [$clog2(DEPTH):0]    count_out;

   modport master (
      output flush_in, enq_valid_in, enq_uop_in, deq_ready_in,
      input  enq_ready_out, deq_valid_out, deq_uop_out, count_out
   );

   modport slave (
      input  flush_in, enq_valid_in, enq_uop_in, deq_ready_in,
      output enq_ready_out, deq_valid_out, deq_uop_out, count_out
   );

endinterface

// File: rtl/uop_lane_compact.sv
// Maps sparse enqueue lanes onto consecutive slot offsets from the tail.
module uop_lane_compact #(
   parameter  int WIDTH = 4,
   localparam int OFF_W = (WIDTH > 1) ? $clog2(WIDTH) : 1,
   localparam int POP_W = $clog2(WIDTH) + 1
) (
   input  logic [WIDTH-1:0]            valid_i,
   output logic [WIDTH-1:0][OFF_W-1:0] offset_o,
   output logic [POP_W-1:0]            count_o
);

   logic [POP_W-1:0] run;

   // Each lane's offset is the number of valid lanes older than it.
   always_comb begin
      run      = '0;
      offset_o = '0;
      for (int i = 0; i < WIDTH; i++) begin
         offset_o[i] = OFF_W'(run);
         run         = run + POP_W'(valid_i[i]);
      end
      count_o = run;
   end

endmodule

// File: rtl/uop_queue.sv
// Circular uop buffer between decode and rename; flushed whole on mispredict.
module uop_queue
   import uop_pkg::*;
#(
   parameter int DEPTH = UQ_DEPTH,
   parameter int WIDTH = INSTR_Q_WIDTH
) (
   input  logic        clk_in,
   input  logic        rst_N_in,
   uop_queue_if.slave  q
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam int OFF_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam int POP_W = $clog2(WIDTH) + 1;

   logic [PTR_W-1:0] head_q, head_d;
   logic [PTR_W-1:0] tail_q, tail_d;
   logic [CNT_W-1:0] count_q, count_d;
   uop_t             slot_q [DEPTH];

   logic [WIDTH-1:0][OFF_W-1:0] lane_off;
   logic [POP_W-1:0]            enq_pop;
   logic                        enq_ready;
   logic                        enq_fire;
   logic                        deq_fire;
   logic [PTR_W-1:0]            enq_adv;
   logic [PTR_W-1:0]            deq_adv;
   logic [WIDTH-1:0]            deq_valid;
   uop_t [WIDTH-1:0]            deq_uop;

   uop_lane_compact #(.WIDTH(WIDTH)) u_compact (
      .valid_i  (q.enq_valid_in),
      .offset_o (lane_off),
      .count_o  (enq_pop)
   );

   // Ready looks only at registered occupancy so decode never depends on deq_ready_in.
   assign enq_ready = (CNT_W'(DEPTH) - count_q) >= CNT_W'(WIDTH);
   assign enq_fire  = enq_ready && (|q.enq_valid_in) && !q.flush_in;
   assign deq_fire  = q.deq_ready_in && (count_q != '0) && !q.flush_in;

   always_comb begin
      enq_adv = '0;
      deq_adv = '0;
      if (enq_fire) begin
         enq_adv = PTR_W'(enq_pop);
      end
      if (deq_fire) begin
         deq_adv = (count_q < CNT_W'(WIDTH)) ? count_q[PTR_W-1:0] : PTR_W'(WIDTH);
      end
      head_d  = head_q + deq_adv;
      tail_d  = tail_q + enq_adv;
      count_d = count_q + CNT_W'(enq_adv) - CNT_W'(deq_adv);
      if (q.flush_in) begin
         head_d  = '0;
         tail_d  = '0;
         count_d = '0;
      end
   end

   always_ff @(posedge clk_in) begin
      if (!rst_N_in) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
      end else begin
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
      end
   end

   always_ff @(posedge clk_in) begin
      if (enq_fire) begin
         for (int i = 0; i < WIDTH; i++) begin
            if (q.enq_valid_in[i]) begin
               slot_q[tail_q + PTR_W'(lane_off[i])] <= q.enq_uop_in[i];
            end
         end
      end
   end

   // Flush kills the group combinationally so a wrong-path group is never taken.
   always_comb begin
      deq_valid = '0;
      deq_uop   = '0;
      for (int i = 0; i < WIDTH; i++) begin
         deq_valid[i] = (CNT_W'(i) < count_q) && !q.flush_in;
         deq_uop[i]   = slot_q[head_q + PTR_W'(i)];
      end
   end

   assign q.deq_valid_out = deq_valid;
   assign q.deq_uop_out   = deq_uop;
   assign q.enq_ready_out = enq_ready;
   assign q.count_out     = count_q;

endmodule

// File: tb/tb_uop_queue.sv
// Testbench for uop_queue: vector table plus hand sequences, backed by a queue scoreboard.
module tb_uop_queue;
   import uop_pkg::*;

   localparam int W = 4;
   localparam int D = 16;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   uop_queue_if #(.WIDTH(W), .DEPTH(D)) bus ();

   uop_queue #(.DEPTH(D), .WIDTH(W)) dut (
      .clk_in   (clk),
      .rst_N_in (rst_n),
      .q        (bus)
   );

   int   total = 0;
   int   bad   = 0;
   uop_t model_q [$];

   typedef struct {
      logic [3:0]  v;
      logic [31:0] pcb;
      logic        dr;
      logic        fl;
      int          cnt;
      logic [3:0]  vld;
      logic        rdy;
      logic [31:0] pc0;
   } vec_t;

   vec_t tbl [11];

   function automatic uop_t mk(input logic [31:0] pc);
      uop_t u;
      u.pc     = pc;
      u.opcode = pc[8:2] ^ 7'h33;
      u.rd     = pc[6:2];
      u.rs1    = pc[11:7];
      u.rs2    = pc[16:12];
      u.imm    = ~pc;
      return u;
   endfunction

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic drive(input logic [3:0] v, input logic [31:0] pcb, input logic dr, input logic fl);
      bus.enq_valid_in = v;
      for (int i = 0; i < W; i++) bus.enq_uop_in[i] = mk(pcb + 32'(4 * i));
      bus.deq_ready_in = dr;
      bus.flush_in     = fl;
   endtask

   // Compare the DUT's current outputs against the reference queue.
   task automatic pre_check();
      int         n;
      logic [3:0] ev;
      n = model_q.size();
      chk("sb_count", 128'(bus.count_out), 128'(n));
      chk("sb_ready", 128'(bus.enq_ready_out), 128'(((D - n) >= W) ? 1 : 0));
      for (int i = 0; i < W; i++) ev[i] = (i < n) && !bus.flush_in;
      chk("sb_valid", 128'(bus.deq_valid_out), 128'(ev));
      for (int i = 0; i < W; i++)
         if (ev[i]) chk($sformatf("sb_uop%0d", i), 128'(bus.deq_uop_out[i]), 128'(model_q[i]));
   endtask

   // Advance the reference queue by what the inputs request, then clock.
   task automatic edge_step();
      int n;
      bit rdy;
      n   = model_q.size();
      rdy = (D - n) >= W;
      if (!rst_n || bus.flush_in) begin
         model_q.delete();
      end else begin
         if (bus.deq_ready_in)
            for (int k = 0; k < ((n < W) ? n : W); k++) void'(model_q.pop_front());
         if (rdy)
            for (int i = 0; i < W; i++)
               if (bus.enq_valid_in[i]) model_q.push_back(bus.enq_uop_in[i]);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic cycle(input logic [3:0] v, input logic [31:0] pcb, input logic dr, input logic fl);
      drive(v, pcb, dr, fl);
      #1;
      pre_check();
      edge_step();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      tbl[0]  = '{4'b1111, 32'h100,  1'b0, 1'b0,  4, 4'b1111, 1'b1, 32'h100};
      tbl[1]  = '{4'b0000, 32'h0,    1'b1, 1'b0,  0, 4'b0000, 1'b1, 32'h0};
      tbl[2]  = '{4'b1010, 32'h200,  1'b0, 1'b0,  2, 4'b0011, 1'b1, 32'h204};
      tbl[3]  = '{4'b0000, 32'h0,    1'b1, 1'b0,  0, 4'b0000, 1'b1, 32'h0};
      tbl[4]  = '{4'b1111, 32'h1000, 1'b0, 1'b0,  4, 4'b1111, 1'b1, 32'h1000};
      tbl[5]  = '{4'b1111, 32'h1010, 1'b0, 1'b0,  8, 4'b1111, 1'b1, 32'h1000};
      tbl[6]  = '{4'b1111, 32'h1020, 1'b0, 1'b0, 12, 4'b1111, 1'b1, 32'h1000};
      tbl[7]  = '{4'b1111, 32'h1030, 1'b0, 1'b0, 16, 4'b1111, 1'b0, 32'h1000};
      tbl[8]  = '{4'b1111, 32'h1040, 1'b0, 1'b0, 16, 4'b1111, 1'b0, 32'h1000};
      tbl[9]  = '{4'b0000, 32'h0,    1'b1, 1'b0, 12, 4'b1111, 1'b1, 32'h1010};
      tbl[10] = '{4'b1111, 32'h1050, 1'b1, 1'b0, 12, 4'b1111, 1'b1, 32'h1020};

      drive(4'b0000, 32'h0, 1'b0, 1'b0);
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      chk("rst_count", 128'(bus.count_out), 128'(0));
      chk("rst_ready", 128'(bus.enq_ready_out), 128'(1));
      chk("rst_valid", 128'(bus.deq_valid_out), 128'(0));

      for (int r = 0; r < 11; r++) begin
         cycle(tbl[r].v, tbl[r].pcb, tbl[r].dr, tbl[r].fl);
         drive(4'b0000, 32'h0, 1'b0, 1'b0);
         #1;
         chk($sformatf("tbl%0d_count", r), 128'(bus.count_out), 128'(tbl[r].cnt));
         chk($sformatf("tbl%0d_valid", r), 128'(bus.deq_valid_out), 128'(tbl[r].vld));
         chk($sformatf("tbl%0d_ready", r), 128'(bus.enq_ready_out), 128'(tbl[r].rdy));
         if (tbl[r].vld[0])
            chk($sformatf("tbl%0d_pc0", r), 128'(bus.deq_uop_out[0].pc), 128'(tbl[r].pc0));
         if (tbl[r].vld[1] && r == 2)
            chk("tbl2_pc1", 128'(bus.deq_uop_out[1].pc), 128'(32'h20C));
      end

      // Clear, then steer head to 14 with four uops for the wrap case.
      cycle(4'b0000, 32'h0, 1'b0, 1'b1);
      chk("flush_idle_count", 128'(bus.count_out), 128'(0));
      cycle(4'b0011, 32'h2000, 1'b0, 1'b0);
      cycle(4'b0000, 32'h0, 1'b1, 1'b0);
      cycle(4'b1111, 32'h3000, 1'b0, 1'b0);
      cycle(4'b1111, 32'h3010, 1'b0, 1'b0);
      cycle(4'b1111, 32'h3020, 1'b0, 1'b0);
      cycle(4'b0000, 32'h0, 1'b1, 1'b0);
      cycle(4'b0000, 32'h0, 1'b1, 1'b0);
      chk("pre_wrap_pc0", 128'(bus.deq_uop_out[0].pc), 128'(32'h3020));
      cycle(4'b1111, 32'h3030, 1'b1, 1'b0);
      chk("wrap_count", 128'(bus.count_out), 128'(4));
      chk("wrap_pc0", 128'(bus.deq_uop_out[0].pc), 128'(32'h3030));
      chk("wrap_pc3", 128'(bus.deq_uop_out[3].pc), 128'(32'h303C));
      cycle(4'b1111, 32'h3040, 1'b1, 1'b0);
      chk("post_wrap_count", 128'(bus.count_out), 128'(4));
      chk("post_wrap_pc0", 128'(bus.deq_uop_out[0].pc), 128'(32'h3040));

      // Flush while enqueue and dequeue are both requested.
      cycle(4'b1111, 32'h4000, 1'b0, 1'b0);
      cycle(4'b0001, 32'h4100, 1'b0, 1'b0);
      chk("pre_flush_count", 128'(bus.count_out), 128'(9));
      drive(4'b1111, 32'h5000, 1'b1, 1'b1);
      #1;
      chk("flush_valid", 128'(bus.deq_valid_out), 128'(0));
      pre_check();
      edge_step();
      drive(4'b0000, 32'h0, 1'b0, 1'b0);
      #1;
      chk("post_flush_count", 128'(bus.count_out), 128'(0));
      chk("post_flush_valid", 128'(bus.deq_valid_out), 128'(0));
      cycle(4'b1111, 32'h6000, 1'b0, 1'b0);
      chk("after_flush_pc0", 128'(bus.deq_uop_out[0].pc), 128'(32'h6000));

      // Reset while the queue holds seven uops and decode keeps pushing.
      cycle(4'b0111, 32'h7000, 1'b0, 1'b0);
      chk("pre_rst_count", 128'(bus.count_out), 128'(7));
      rst_n = 1'b0;
      cycle(4'b1111, 32'h8000, 1'b0, 1'b0);
      rst_n = 1'b1;
      drive(4'b0000, 32'h0, 1'b0, 1'b0);
      #1;
      chk("midrst_count", 128'(bus.count_out), 128'(0));
      chk("midrst_valid", 128'(bus.deq_valid_out), 128'(0));
      chk("midrst_ready", 128'(bus.enq_ready_out), 128'(1));
      cycle(4'b1111, 32'h9000, 1'b1, 1'b0);
      chk("after_rst_pc0", 128'(bus.deq_uop_out[0].pc), 128'(32'h9000));
      cycle(4'b0000, 32'h0, 1'b1, 1'b0);
      cycle(4'b0000, 32'h0, 1'b0, 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
